rst_sequencer: RTL and testbench
================================

# rst_sequencer

Staged reset release controller driven by the bridged system reset. After reset it holds every downstream subsystem in reset for a minimum time and waits for PLL lock. It then releases per-subsystem resets in fixed order with a programmable gap (e.g. clocking, then ADC/DSP, then host interface). Loss of lock or a software reset request re-asserts all subsystem resets and restarts the sequence.

## Interface
- `NUM_STAGES`, 3: number of sequenced reset outputs (>= 1).
- `HOLD_CYCLES`, 16: minimum cycles all stages stay in reset after `rst`/restart (>= 2).
- `STAGE_DELAY`, 8: cycles between successive stage releases (>= 1).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset; highest priority.
- `pll_lock`  in  1  asynchronous PLL lock; synchronised internally by 2 flops reset to 0.
- `soft_rst`  in  1  synchronous restart request, sampled every cycle.
- `stage_rst`  out  NUM_STAGES  per-stage reset, active-high; bit 0 releases first.
- `ready`  out  1  high when all stages are released (state RUN).
- `lock_lost`  out  1  one-cycle pulse on lock-loss abort.
- `lock_loss_cnt`  out  8  count of lock-loss aborts, saturates at 255.

## Operation
- `lock_s` is the 2-flop synchronised `pll_lock`; all decisions use `lock_s`.
- Reset values (while `rst`=1): state HOLD, `stage_rst` all ones, `ready`=0, `lock_lost`=0, `lock_loss_cnt`=0, hold/delay counters 0, stage index 0, sync flops 0.
- States:
  - HOLD:
    - `hold_cnt` increments each cycle.
    - At `hold_cnt`==HOLD_CYCLES-1, go to WAIT_LOCK.
    - `soft_rst` clears `hold_cnt` to 0 and the state stays HOLD.
  - WAIT_LOCK:
    - `soft_rst` goes to HOLD with `hold_cnt`=0; it takes priority over lock.
    - Else, if `lock_s`=1: `stage_rst[0]`<=0, index<=1, `dly_cnt`<=0.
    - Next state is RELEASE, or RUN with `ready`<=1 when NUM_STAGES==1.
  - RELEASE:
    - `dly_cnt` increments.
    - At `dly_cnt`==STAGE_DELAY-1: `stage_rst[index]`<=0, `dly_cnt`<=0, index++.
    - If that was index NUM_STAGES-1, go to RUN and set `ready`<=1 on the same edge.
  - RUN: holding state.
- Abort, in RELEASE or RUN only:
  - Trigger: `soft_rst`=1 or `lock_s`=0.
  - Action: go to HOLD; `stage_rst` all ones, `ready`<=0, `hold_cnt`<=0, index<=0.
  - Only when `lock_s`=0 and `soft_rst`=0 (a pure lock-loss abort) is the abort counted: `lock_lost`<=1 for one cycle and `lock_loss_cnt` increments, saturating.
  - An abort caused by `soft_rst` never counts, even if lock is also low.
- Lock dropping in HOLD or WAIT_LOCK is not an abort and is not counted. The sequencer simply waits.
- `stage_rst` bits only ever go 1->0 in ascending index order. Each bit goes 0->1 only through `rst` or an abort, and then all bits rise together.
- `lock_loss_cnt` is cleared only by `rst`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Assertion: `rst` or an abort trigger sampled at edge n gives `stage_rst` all ones after edge n.
- Edge numbering: let E0 be the first edge with `rst`=0, and H = HOLD_CYCLES.
  - HOLD covers E0..E(H-1).
  - With `pll_lock` steady high, `lock_s`=1 after E1.
  - `stage_rst[0]` falls after E(H).
- `stage_rst[i]` falls STAGE_DELAY*i edges after `stage_rst[0]`.
- `ready` rises on the same edge as `stage_rst[NUM_STAGES-1]`.
- Default timeline: stage0 after E16, stage1 after E24, stage2 after E32, `ready` after E32.
- Restart after abort: the abort edge counts as the first restart edge. Release resumes exactly as from reset, so stage0 falls H+1 edges after the abort edge if lock is present.
- `rst` mid-sequence or in RUN overrides everything on the next edge.
- `lock_lost` is never asserted for two consecutive cycles.

## Test plan
- Power-up, defaults, `pll_lock`=1 throughout, `rst` high 5 cycles -> `stage_rst`=3'b111 during reset; bits 0/1/2 fall after E16/E24/E32; `ready`=1 after E32; `lock_lost` never pulses.
- `pll_lock` low until E40, then high -> `stage_rst`=3'b111 until lock_s rises; stage0 falls on the first WAIT_LOCK edge sampling `lock_s`=1, stages 1/2 follow at +8/+16; `lock_loss_cnt`=0.
- In RUN, drop `pll_lock` for 20 cycles -> all ones one edge after `lock_s` falls; `ready`=0; single `lock_lost` pulse; `lock_loss_cnt`=1; full re-release once lock returns.
- `soft_rst` pulse at RELEASE with only stage0 released -> all ones next edge, no `lock_lost`, count unchanged; stage0 falls again 17 edges after the pulse edge.
- 300 lock-loss aborts -> `lock_loss_cnt` saturates at 255; `rst` clears it to 0.
- NUM_STAGES=1, HOLD_CYCLES=2 -> `stage_rst[0]` and `ready` change on the same edge, E2.

Source files
------------

// File: rtl/rst_sequencer.sv
// Staged reset release controller: holds all subsystems in reset, waits for PLL
// lock, then releases stage resets in ascending order with a fixed gap.
module rst_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  input  logic                  soft_rst,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [7:0]            lock_loss_cnt
);

  localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DLY_W  = (STAGE_DELAY > 2) ? $clog2(STAGE_DELAY) : 1;
  localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES + 1) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;
  logic [DLY_W-1:0]      dly_cnt_reg, dly_cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [NUM_STAGES-1:0] stage_rst_reg, stage_rst_next;
  logic                  ready_reg, ready_next;
  logic                  lock_lost_reg, lock_lost_next;
  logic [7:0]            loss_cnt_reg, loss_cnt_next;
  logic                  sync_reg, lock_s_reg;
  logic                  abort;
  logic [NUM_STAGES-1:0] release_mask;

  // One-hot mask selecting the stage currently addressed by the release index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_release_mask
      assign release_mask[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign abort = ((state_reg == ST_RELEASE) || (state_reg == ST_RUN)) &&
                 (soft_rst || !lock_s_reg);

  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = hold_cnt_reg;
    dly_cnt_next   = dly_cnt_reg;
    idx_next       = idx_reg;
    stage_rst_next = stage_rst_reg;
    ready_next     = ready_reg;
    lock_lost_next = 1'b0;
    loss_cnt_next  = loss_cnt_reg;

    if (abort) begin
      state_next     = ST_HOLD;
      hold_cnt_next  = '0;
      dly_cnt_next   = '0;
      idx_next       = '0;
      stage_rst_next = '1;
      ready_next     = 1'b0;
      // Only a pure lock loss is counted; a software restart never is.
      if (!soft_rst) begin
        lock_lost_next = 1'b1;
        if (loss_cnt_reg != 8'hFF) begin
          loss_cnt_next = loss_cnt_reg + 8'd1;
        end
      end
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (soft_rst) begin
            hold_cnt_next = '0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_next = '0;
            state_next    = ST_WAIT_LOCK;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (soft_rst) begin
            state_next    = ST_HOLD;
            hold_cnt_next = '0;
          end else if (lock_s_reg) begin
            stage_rst_next = stage_rst_reg & ~release_mask;
            idx_next       = IDX_W'(1);
            dly_cnt_next   = '0;
            if (NUM_STAGES == 1) begin
              state_next = ST_RUN;
              ready_next = 1'b1;
            end else begin
              state_next = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (dly_cnt_reg == DLY_LAST) begin
            stage_rst_next = stage_rst_reg & ~release_mask;
            dly_cnt_next   = '0;
            idx_next       = idx_reg + 1'b1;
            if (idx_reg == IDX_LAST) begin
              state_next = ST_RUN;
              ready_next = 1'b1;
            end
          end else begin
            dly_cnt_next = dly_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_HOLD;
      hold_cnt_reg  <= '0;
      dly_cnt_reg   <= '0;
      idx_reg       <= '0;
      stage_rst_reg <= '1;
      ready_reg     <= 1'b0;
      lock_lost_reg <= 1'b0;
      loss_cnt_reg  <= 8'd0;
      sync_reg      <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      dly_cnt_reg   <= dly_cnt_next;
      idx_reg       <= idx_next;
      stage_rst_reg <= stage_rst_next;
      ready_reg     <= ready_next;
      lock_lost_reg <= lock_lost_next;
      loss_cnt_reg  <= loss_cnt_next;
      sync_reg      <= pll_lock;
      lock_s_reg    <= sync_reg;
    end
  end

  assign stage_rst     = stage_rst_reg;
  assign ready         = ready_reg;
  assign lock_lost     = lock_lost_reg;
  assign lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed phase table, hand sequences for
// saturation and the single-stage variant, and randomized stimulus vs a reference model.
module tb_rst_sequencer;

  localparam int MN = 3;
  localparam int MH = 16;
  localparam int MD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b1;
  logic       soft_rst = 1'b0;
  logic [2:0] stage_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_cnt;

  logic       rst2 = 1'b1;
  logic       pll2 = 1'b1;
  logic       soft2 = 1'b0;
  logic [0:0] stage_rst2;
  logic       ready2;
  logic       lock_lost2;
  logic [7:0] lock_loss_cnt2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rst_sequencer #(.NUM_STAGES(MN), .HOLD_CYCLES(MH), .STAGE_DELAY(MD)) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .soft_rst(soft_rst),
    .stage_rst(stage_rst), .ready(ready), .lock_lost(lock_lost),
    .lock_loss_cnt(lock_loss_cnt)
  );

  rst_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(2), .STAGE_DELAY(8)) dut1 (
    .clk(clk), .rst(rst2), .pll_lock(pll2), .soft_rst(soft2),
    .stage_rst(stage_rst2), .ready(ready2), .lock_lost(lock_lost2),
    .lock_loss_cnt(lock_loss_cnt2)
  );

  // Reference model: released-stage count, hold progress and gap timer.
  bit m_p1, m_p2;
  bit m_in_hold;
  int m_hold_elapsed;
  int m_released;
  int m_gap;
  bit m_lost;
  int m_cnt;

  task automatic model_step(input bit r, input bit s, input bit l);
    bit lk;
    lk = m_p2;
    if (r) begin
      m_p1 = 0; m_p2 = 0; m_in_hold = 1; m_hold_elapsed = 0;
      m_released = 0; m_gap = 0; m_lost = 0; m_cnt = 0;
      return;
    end
    m_p2 = m_p1;
    m_p1 = l;
    m_lost = 0;
    if (m_released > 0) begin
      if (s || !lk) begin
        m_released = 0; m_in_hold = 1; m_hold_elapsed = 0;
        if (!s) begin
          m_lost = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (m_released < MN) begin
        m_gap++;
        if (m_gap == MD) begin
          m_released++;
          m_gap = 0;
        end
      end
    end else if (m_in_hold) begin
      if (s) m_hold_elapsed = 0;
      else begin
        m_hold_elapsed++;
        if (m_hold_elapsed == MH) m_in_hold = 0;
      end
    end else begin
      if (s) begin
        m_in_hold = 1; m_hold_elapsed = 0;
      end else if (lk) begin
        m_released = 1; m_gap = 0;
      end
    end
  endtask

  function automatic logic [2:0] m_stage();
    logic [2:0] v;
    for (int i = 0; i < MN; i++) v[i] = (i >= m_released);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic tick(input bit r, input bit s, input bit l);
    rst = r; soft_rst = s; pll_lock = l;
    @(posedge clk);
    model_step(r, s, l);
    #1;
    chk("model stage_rst", int'(stage_rst), int'(m_stage()));
    chk("model ready", int'(ready), int'(m_released == MN));
    chk("model lock_lost", int'(lock_lost), int'(m_lost));
    chk("model lock_loss_cnt", int'(lock_loss_cnt), m_cnt);
  endtask

  typedef struct {
    string      name;
    int         cycles;
    bit         r;
    bit         s;
    bit         l;
    logic [2:0] stg;
    bit         rdy;
    bit         lost;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input int c, input bit r, input bit s, input bit l,
                     input logic [2:0] stg, input bit rdy, input bit lost, input int cnt);
    vec_t v;
    v.name = n; v.cycles = c; v.r = r; v.s = s; v.l = l;
    v.stg = stg; v.rdy = rdy; v.lost = lost; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lk;
    m_p1 = 0; m_p2 = 0; m_in_hold = 1; m_hold_elapsed = 0;
    m_released = 0; m_gap = 0; m_lost = 0; m_cnt = 0;

    //   name            cyc  r  s  l  stage   rdy lost cnt
    add("reset",          5, 1, 0, 1, 3'b111, 0, 0, 0);
    add("hold E0-E15",   16, 0, 0, 1, 3'b111, 0, 0, 0);
    add("stage0 E16",     1, 0, 0, 1, 3'b110, 0, 0, 0);
    add("stage1 E24",     8, 0, 0, 1, 3'b100, 0, 0, 0);
    add("stage2 E32",     8, 0, 0, 1, 3'b000, 1, 0, 0);
    add("run",           10, 0, 0, 1, 3'b000, 1, 0, 0);
    add("soft in run",    1, 0, 1, 1, 3'b111, 0, 0, 0);
    add("soft rehold",   16, 0, 0, 1, 3'b111, 0, 0, 0);
    add("soft stage0",    1, 0, 0, 1, 3'b110, 0, 0, 0);
    add("lockloss rel",   3, 0, 0, 0, 3'b111, 0, 1, 1);
    add("pulse ends",     1, 0, 0, 1, 3'b111, 0, 0, 1);
    add("relock hold",   15, 0, 0, 1, 3'b111, 0, 0, 1);
    add("relock st0",     1, 0, 0, 1, 3'b110, 0, 0, 1);
    add("relock run",    16, 0, 0, 1, 3'b000, 1, 0, 1);
    add("run lockloss",   3, 0, 0, 0, 3'b111, 0, 1, 2);
    add("lock low hold", 17, 0, 0, 0, 3'b111, 0, 0, 2);
    add("lock back",      2, 0, 0, 1, 3'b111, 0, 0, 2);
    add("lock back st0",  1, 0, 0, 1, 3'b110, 0, 0, 2);
    add("lock back run", 16, 0, 0, 1, 3'b000, 1, 0, 2);
    add("reset nolock",   5, 1, 0, 0, 3'b111, 0, 0, 0);
    add("nolock E0-39",  40, 0, 0, 0, 3'b111, 0, 0, 0);
    add("lock E40-41",    2, 0, 0, 1, 3'b111, 0, 0, 0);
    add("late st0 E42",   1, 0, 0, 1, 3'b110, 0, 0, 0);
    add("late run",      16, 0, 0, 1, 3'b000, 1, 0, 0);
    add("rst in run",     1, 1, 0, 1, 3'b111, 0, 0, 0);

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].cycles; c++) tick(vecs[k].r, vecs[k].s, vecs[k].l);
      chk({vecs[k].name, " stage_rst"}, int'(stage_rst), int'(vecs[k].stg));
      chk({vecs[k].name, " ready"}, int'(ready), int'(vecs[k].rdy));
      chk({vecs[k].name, " lock_lost"}, int'(lock_lost), int'(vecs[k].lost));
      chk({vecs[k].name, " lock_loss_cnt"}, int'(lock_loss_cnt), vecs[k].cnt);
      $display("vec %0d %s: stage_rst=%b ready=%b lock_lost=%b cnt=%0d",
               k, vecs[k].name, stage_rst, ready, lock_lost, lock_loss_cnt);
    end

    // 300 lock-loss aborts, each taken during RELEASE.
    for (int a = 0; a < 300; a++) begin
      for (int c = 0; c < 20; c++) tick(0, 0, 1);
      for (int c = 0; c < 3; c++) tick(0, 0, 0);
    end
    chk("saturate cnt", int'(lock_loss_cnt), 255);
    chk("saturate stage_rst", int'(stage_rst), 7);
    $display("seq saturate: lock_loss_cnt=%0d", lock_loss_cnt);
    tick(1, 0, 1);
    chk("rst clears cnt", int'(lock_loss_cnt), 0);
    $display("seq rst clear: lock_loss_cnt=%0d", lock_loss_cnt);

    // Randomized run against the model.
    lk = 1;
    tick(1, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) lk = ~lk;
      tick(($urandom_range(0, 999) == 0), ($urandom_range(0, 149) == 0), lk);
    end
    $display("seq random: 3000 cycles, lock_loss_cnt=%0d", lock_loss_cnt);

    // Single-stage, HOLD_CYCLES=2 variant: stage and ready fall/rise together at E2.
    chk("ns1 reset stage_rst", int'(stage_rst2), 1);
    chk("ns1 reset ready", int'(ready2), 0);
    rst2 = 1'b0;
    tick(0, 0, 1);
    chk("ns1 E0 stage_rst", int'(stage_rst2), 1);
    chk("ns1 E0 ready", int'(ready2), 0);
    tick(0, 0, 1);
    chk("ns1 E1 stage_rst", int'(stage_rst2), 1);
    chk("ns1 E1 ready", int'(ready2), 0);
    tick(0, 0, 1);
    chk("ns1 E2 stage_rst", int'(stage_rst2), 0);
    chk("ns1 E2 ready", int'(ready2), 1);
    chk("ns1 lock_lost", int'(lock_lost2), 0);
    $display("seq ns1: stage_rst=%b ready=%b", stage_rst2, ready2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
